matrix_loader: RTL
==================

# matrix_loader

Streaming front end for the video matrix datapath. It accepts one signed element per handshake in row-major order and assembles a full M×N matrix in a fill buffer. When the matrix is complete it copies it to a held output register and pulses a valid strobe. It sits directly upstream of the matrix multiplier and drives its matrix operand and input-valid; the multiplier samples the matrix on that strobe.

## Interface
- DATA_WIDTH, 16, element width in bits, signed two's complement, passed through unchanged
- M, 4, matrix rows (≥1)
- N, 4, matrix columns (≥1)
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- clr  in  1  synchronous clear: discards the partial matrix, counters to 0
- s_valid  in  1  element valid
- s_ready  out  1  element ready; transfer occurs when s_valid && s_ready on a rising edge
- s_data  in  DATA_WIDTH  signed element
- s_last  in  1  marks the final element of a matrix; sampled only on transfer
- mat_o  out  [M-1:0][N-1:0] × DATA_WIDTH  assembled matrix, held between updates
- vld_o  out  1  one-cycle pulse: mat_o has just been updated
- err_o  out  1  one-cycle pulse: framing error, partial matrix dropped

## Operation
- Row counter r (0..M-1) and column counter c (0..N-1). Increment with mux/compare logic; no divide.
- Each transfer writes s_data into fill[r][c], then advances: c+1, wrapping at N-1 to 0 with r+1; r wraps at M-1 to 0.
- Final position is r==M-1 and c==N-1.
- Transfer at final position with s_last=1:
  - mat_o <= fill with the current s_data merged into [M-1][N-1], in the same edge.
  - vld_o pulses. Counters go to 0.
- Transfer at final position with s_last=0: err_o pulses, no mat_o update, counters go to 0.
- Transfer at a non-final position with s_last=1 (early last): err_o pulses, no mat_o update, counters go to 0. The element is discarded.
- clr=1: counters go to 0 and the fill contents are ignored. mat_o and vld_o are unaffected, except that a transfer on the same edge is dropped. clr has priority over a transfer.
- s_ready is 0 in reset and 1 from the first rising edge after rst_n deasserts. It is never dropped otherwise: the block stores a complete matrix every N·M transfers with no backpressure.
- mat_o changes only on a successful completion. Downstream may sample it at any time after vld_o.

## Timing
- Reset values:
  - s_ready=0, vld_o=0, err_o=0, mat_o all zeros, r=c=0.
  - Fill buffer contents are don't-care (no reset required).
- Latency: vld_o and the new mat_o are visible in the cycle after the edge that accepts the last element (1 clock).
- Throughput: one element per clock. Back-to-back matrices are sustained. The first element of matrix k+1 may be accepted on the edge after the last element of matrix k, or on the same cycle vld_o is high.
- vld_o and err_o are each exactly one cycle wide. They never assert together.
- s_valid may drop between elements. With no transfer, counters and buffers hold.
- rst_n asserted mid-matrix: all outputs return to reset values immediately (asynchronously). The partial matrix is lost. Loading restarts at [0][0] once s_ready returns.
- M=N=1: every transfer is the final position. s_last=1 gives vld_o; s_last=0 gives err_o.

## Test plan
- Load values 1..16 on 16 consecutive cycles, s_last on the 16th:
  - vld_o is high exactly one cycle, the cycle after the 16th transfer.
  - mat_o[0][0]=1, mat_o[1][2]=7, mat_o[3][3]=16. err_o never asserts.
- Same data with s_valid low on alternate cycles:
  - identical mat_o; vld_o one cycle after the final accepted element.
  - s_ready stays 1 throughout.
- Early last on the 5th element:
  - err_o pulses, no vld_o, mat_o unchanged.
  - A following clean 16-element load of 101..116 gives mat_o[0][0]=101, mat_o[3][3]=116.
- Missing last on the 16th element: err_o pulses, mat_o holds its previous contents. A retry with s_last gives vld_o.
- Back-to-back loads of 32 consecutive elements (1..16 then 17..32):
  - vld_o pulses at the cycle after the 16th and after the 32nd transfer.
  - mat_o holds matrix 1 during the second load, then mat_o[0][0]=17.
- rst_n low after 8 transfers:
  - mat_o goes to zeros and s_ready to 0 immediately.
  - After release, 16 elements load from [0][0]. Separately, clr after 8 transfers drops the partial matrix with no err_o.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: assembles a row-major stream of signed elements into an
// M x N matrix and presents each complete matrix on a held output with a
// one-cycle valid strobe. Framing errors (early or missing last) drop the
// partial matrix and pulse err_o instead.
module matrix_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_WIDTH-1:0]                s_data,
    input  logic                                 s_last,
    output logic [M-1:0][N-1:0][DATA_WIDTH-1:0]  mat_o,
    output logic                                 vld_o,
    output logic                                 err_o
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

    logic                  ready_reg;
    logic                  vld_reg;
    logic                  err_reg;
    logic [RW-1:0]         row_reg;
    logic [RW-1:0]         row_next;
    logic [CW-1:0]         col_reg;
    logic [CW-1:0]         col_next;

    // Fill buffer holds the partial matrix; it needs no reset because every
    // position is rewritten before a completion can copy it out.
    logic [DATA_WIDTH-1:0] fill_reg  [M][N];
    logic [DATA_WIDTH-1:0] mat_reg   [M][N];
    logic [DATA_WIDTH-1:0] load_next [M][N];

    logic accept;
    logic at_final;
    logic complete;
    logic frame_err;

    // A transfer is dropped entirely when clr arrives on the same edge.
    assign accept    = s_valid && ready_reg && !clr;
    assign at_final  = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign complete  = accept && at_final && s_last;
    // Error when last and final position disagree: early last or missing last.
    assign frame_err = accept && (at_final != s_last);

    assign s_ready = ready_reg;
    assign vld_o   = vld_reg;
    assign err_o   = err_reg;

    // Snapshot for the output register: the buffered elements plus the
    // element arriving right now in the final slot, so completion costs no
    // extra cycle.
    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                if ((gi == M - 1) && (gj == N - 1)) begin : g_tail
                    assign load_next[gi][gj] = s_data;
                end else begin : g_body
                    assign load_next[gi][gj] = fill_reg[gi][gj];
                end
                assign mat_o[gi][gj] = mat_reg[gi][gj];
            end
        end
    endgenerate

    // Next position: wrap column into row, restart on clear, completion or error.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clr) begin
            row_next = '0;
            col_next = '0;
        end else if (accept) begin
            if (at_final || s_last) begin
                row_next = '0;
                col_next = '0;
            end else if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Position counters, ready flag and the one-cycle status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg   <= '0;
            col_reg   <= '0;
            ready_reg <= 1'b0;
            vld_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            row_reg   <= row_next;
            col_reg   <= col_next;
            ready_reg <= 1'b1;
            vld_reg   <= complete;
            err_reg   <= frame_err;
        end
    end

    // Write each accepted element into its slot of the fill buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_reg[row_reg][col_reg] <= s_data;
        end
    end

    // Held output matrix; only a clean completion replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    mat_reg[i][j] <= '0;
                end
            end
        end else if (complete) begin
            mat_reg <= load_next;
        end
    end

endmodule
